// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 register sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t      - sequencer FSM states
//   entry_t      - classification of a ROM word (write / delay / end)
//   rom_entry_t  - {reg, val} view of a 16-bit ROM word
//   END_MARK, DELAY_MARK, OV7670_WR_ID
package ov7670_pkg;

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    DELAY = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [15:0] END_MARK     = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK   = 16'hFFF0;
  localparam logic [7:0]  OV7670_WR_ID = 8'h42;

  typedef enum logic [1:0] {
    ENT_WRITE = 2'd0,
    ENT_DELAY = 2'd1,
    ENT_END   = 2'd2
  } entry_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] val;
  } rom_entry_t;

  // Marker words take precedence over a plain register write.
  function automatic entry_t classify_entry(input logic [15:0] e);
    if (e == END_MARK) begin
      return ENT_END;
    end else if (e == DELAY_MARK) begin
      return ENT_DELAY;
    end else begin
      return ENT_WRITE;
    end
  endfunction

endpackage

// File: rtl/ov7670_reg_sequencer.sv
// Walks a {reg, val} ROM and issues each entry as an SCCB write; handles power-up wait, delay entries, NACK retry, resend.
// Latency: first sccb_start PWRUP_CYC+3 cycles after reset release; sccb_done to next sccb_start is 4 cycles.
// Backpressure: waits in ISSUE while sccb_busy; never aborts an SCCB transaction in flight (resend is deferred to sccb_done).
//
// Ports:
//   clk50, rst_n            - 50 MHz clock, async active-low reset
//   resend                  - one-cycle pulse, restarts the configuration pass
//   rom_addr / rom_data     - synchronous ROM, data valid one cycle after address
//   sccb_start/id/reg/val   - write request to the SCCB master (reg/val held start..done)
//   sccb_busy/done/nack     - SCCB master status; nack qualifies done
//   config_finished         - end marker (or last ROM address) reached
//   cfg_err                 - sticky: some write was skipped after exhausting retries
//   write_count             - acknowledged writes in the current pass
module ov7670_reg_sequencer
  import ov7670_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter logic [7:0]  DEV_ID     = OV7670_WR_ID,
  parameter int unsigned PWRUP_CYC  = 50000,
  parameter int unsigned SETTLE_CYC = 500000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              resend,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic [7:0]        sccb_id,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_val,
  input  logic              sccb_busy,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic              config_finished,
  output logic              cfg_err,
  output logic [ADDR_W-1:0] write_count
);

  // One down-counter serves both the power-up wait and delay entries,
  // so it is sized for the larger of the two.
  localparam int unsigned CNT_MAX = (PWRUP_CYC > SETTLE_CYC) ? PWRUP_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   PWRUP_LD  = CNT_W'(PWRUP_CYC);
  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = '1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic               pending;

  rom_entry_t         entry;
  entry_t             entry_kind;

  logic               restart_req;  // resend seen this cycle or deferred from WAIT
  logic               do_restart;
  logic               do_advance;

  assign sccb_id    = DEV_ID;
  assign entry      = rom_entry_t'(rom_data);
  assign entry_kind = classify_entry(rom_data);
  assign restart_req = pending | resend;

  // Restart and advance are transition actions shared by several states;
  // deciding them here keeps the sequential block a plain per-state case.
  always_comb begin
    do_restart = 1'b0;
    do_advance = 1'b0;
    case (state)
      FETCH, LATCH, ISSUE, DONE: begin
        do_restart = resend;
      end
      DELAY: begin
        do_restart = resend;
        // Counting ends on the cycle the counter would reach zero.
        do_advance = !resend && (cnt <= CNT_ONE);
      end
      WAIT: begin
        // A resend during a transaction only takes effect at its completion,
        // and that completion is then neither counted nor retried.
        do_restart = sccb_done && restart_req;
        do_advance = sccb_done && !restart_req &&
                     (!sccb_nack || (retry == RETRY_LIM));
      end
      default: begin
        do_restart = 1'b0;
        do_advance = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state           <= PWRUP;
      cnt             <= PWRUP_LD;
      rom_addr        <= '0;
      sccb_start      <= 1'b0;
      sccb_reg        <= 8'h00;
      sccb_val        <= 8'h00;
      config_finished <= 1'b0;
      cfg_err         <= 1'b0;
      write_count     <= '0;
      retry           <= '0;
      pending         <= 1'b0;
    end else begin
      sccb_start <= 1'b0;

      if (do_restart) begin
        // Fresh pass from entry 0; the power-up wait is not repeated.
        state           <= FETCH;
        rom_addr        <= '0;
        config_finished <= 1'b0;
        cfg_err         <= 1'b0;
        write_count     <= '0;
        retry           <= '0;
        pending         <= 1'b0;
        cnt             <= '0;
      end else if (do_advance) begin
        if (state == WAIT) begin
          if (sccb_nack) begin
            cfg_err <= 1'b1;  // retries exhausted, entry skipped
          end else begin
            write_count <= write_count + 1'b1;
          end
        end
        cnt <= '0;
        // A ROM without an end marker stops at its last entry instead of
        // wrapping back to entry 0 and rewriting the sensor forever.
        if (rom_addr == LAST_ADDR) begin
          state           <= DONE;
          config_finished <= 1'b1;
        end else begin
          rom_addr <= rom_addr + 1'b1;
          state    <= FETCH;
        end
      end else begin
        case (state)
          PWRUP: begin
            if (cnt > CNT_ONE) begin
              cnt <= cnt - 1'b1;
            end else begin
              cnt   <= '0;
              state <= FETCH;
            end
          end

          FETCH: begin
            // rom_addr was set on entry; the ROM answers one cycle later.
            state <= LATCH;
          end

          LATCH: begin
            case (entry_kind)
              ENT_END: begin
                state           <= DONE;
                config_finished <= 1'b1;
              end
              ENT_DELAY: begin
                cnt   <= SETTLE_LD;
                state <= DELAY;
              end
              default: begin
                sccb_reg <= entry.reg_addr;
                sccb_val <= entry.val;
                retry    <= '0;
                state    <= ISSUE;
              end
            endcase
          end

          ISSUE: begin
            if (!sccb_busy) begin
              sccb_start <= 1'b1;
              state      <= WAIT;
            end
          end

          WAIT: begin
            if (sccb_done) begin
              // Only a NACK with retries left reaches here.
              retry <= retry + 1'b1;
              state <= ISSUE;
            end else if (resend) begin
              pending <= 1'b1;
            end
          end

          DELAY: begin
            cnt <= cnt - 1'b1;
          end

          DONE: begin
            state <= DONE;
          end

          default: begin
            state <= PWRUP;
            cnt   <= PWRUP_LD;
          end
        endcase
      end
    end
  end

endmodule
